tiniest_1bit_am_receiver: RTL and testbench



---
 rtl/tiniest_1bit_am_receiver_pkg.sv | 32 +++
 rtl/tiniest_1bit_am_receiver_cic3_decim.sv | 52 +++++
 rtl/tiniest_1bit_am_receiver.sv | 144 ++++++++++++++
 tb/tb_tiniest_1bit_am_receiver.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tiniest_1bit_am_receiver_pkg.sv
// Shared constants and helpers for the 1-bit AM receiver tile.
// Pin bit positions live here so the top and any wrapper agree on the pinout.
package tiniest_1bit_am_receiver_pkg;

  localparam int TW_W     = 24;
  localparam int DEC_LOG2 = 8;
  localparam int CIC_W    = 1 + 3 * DEC_LOG2 + 1;
  localparam int IQ_W     = 16;
  localparam int MAG_W    = IQ_W + 1;
  localparam int AUDIO_W  = 8;
  localparam int AUDIO_SHIFT = 9;

  // ui_in bit positions
  localparam int UI_RF_BIT    = 0;
  localparam int UI_SEL_LSB   = 1;
  localparam int UI_TW_WE_BIT = 3;
  localparam int UI_GAIN_LSB  = 4;

  // uo_out bit positions
  localparam int UO_SD_BIT     = 0;
  localparam int UO_LO_I_BIT   = 1;
  localparam int UO_STROBE_BIT = 2;
  localparam int UO_AUDIO_LSB  = 3;

  // Magnitude of a signed sample, widened by one bit so -2^(IQ_W-1) is exact.
  function automatic logic [MAG_W-1:0] mag_abs(input logic signed [IQ_W-1:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[IQ_W-1], v};
    return v[IQ_W-1] ? (~ext + MAG_W'(1)) : ext;
  endfunction

endpackage

// File: rtl/tiniest_1bit_am_receiver_cic3_decim.sv
// Third-order CIC decimator for a 1-bit (+1/-1) input stream.
// Integrators run every clock; combs and the output register advance on tick.
module cic3_decim #(
  parameter int CIC_W = 26,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_bit,
  input  logic                    tick,
  output logic signed [OUT_W-1:0] sample
);

  logic signed [CIC_W-1:0] in_val;
  logic signed [CIC_W-1:0] int1, int2, int3;
  logic signed [CIC_W-1:0] dly1, dly2, dly3;
  logic signed [CIC_W-1:0] comb1, comb2, comb3;
  logic                    unused_lsbs;

  assign in_val = in_bit ? {{(CIC_W-1){1'b0}}, 1'b1} : {CIC_W{1'b1}};

  assign comb1 = int3 - dly1;
  assign comb2 = comb1 - dly2;
  assign comb3 = comb2 - dly3;

  assign unused_lsbs = ^comb3[CIC_W-OUT_W-1:0];

  // Wrap-around arithmetic is intentional: comb differences undo integrator overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      int1   <= '0;
      int2   <= '0;
      int3   <= '0;
      dly1   <= '0;
      dly2   <= '0;
      dly3   <= '0;
      sample <= '0;
    end else begin
      // NOTE: non-blocking, so each integrator accumulates last cycle's value of the stage before it.
      int1 <= int1 + in_val;
      int2 <= int2 + int1;
      int3 <= int3 + int2;
      if (tick) begin
        dly1   <= int3;
        dly2   <= comb1;
        dly3   <= comb2;
        sample <= comb3[CIC_W-1 -: OUT_W];
      end
    end
  end

endmodule

// File: rtl/tiniest_1bit_am_receiver.sv
// Direct-conversion AM receiver: 1-bit RF x quadrature NCO -> CIC -> envelope -> sigma-delta audio.
// Top-level tile design; drives every tile output.
module tiniest_1bit_am_receiver #(
  parameter int TW_W     = tiniest_1bit_am_receiver_pkg::TW_W,
  parameter int DEC_LOG2 = tiniest_1bit_am_receiver_pkg::DEC_LOG2,
  parameter int CIC_W    = tiniest_1bit_am_receiver_pkg::CIC_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import tiniest_1bit_am_receiver_pkg::*;

  logic                     rf_meta, rf_sync;
  logic [TW_W-1:0]          tw;
  logic [TW_W-1:0]          phase;
  logic                     lo_i, lo_q;
  logic                     i_bit, q_bit;
  logic [DEC_LOG2-1:0]      dec_cnt;
  logic                     dec_tick;
  logic                     strobe_q;
  logic signed [IQ_W-1:0]   i_sample, q_sample;
  logic [MAG_W-1:0]         abs_i, abs_q, env_max, env_min, mag;
  logic [23:0]              scaled;
  logic [14:0]              shifted;
  logic [AUDIO_W-1:0]       audio_next, audio;
  logic [AUDIO_W:0]         sd_acc;
  logic [1:0]               tw_sel;
  logic                     tw_we;
  logic [2:0]               gain;
  logic                     unused_inputs;

  assign tw_sel = ui_in[UI_SEL_LSB +: 2];
  assign tw_we  = ui_in[UI_TW_WE_BIT];
  assign gain   = ui_in[UI_GAIN_LSB +: 3];

  assign unused_inputs = ^{ena, ui_in[7]};

  // Synchronizer, tuning register file and NCO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_meta <= 1'b0;
      rf_sync <= 1'b0;
      tw      <= '0;
      phase   <= '0;
    end else begin
      rf_meta <= ui_in[UI_RF_BIT];
      rf_sync <= rf_meta;
      phase   <= phase + tw;
      if (tw_we && tw_sel != 2'd3) begin
        tw[{tw_sel, 3'b000} +: 8] <= uio_in;
      end
    end
  end

  assign lo_i  = phase[TW_W-1];
  assign lo_q  = phase[TW_W-1] ^ phase[TW_W-2];
  assign i_bit = rf_sync ^ lo_i;
  assign q_bit = rf_sync ^ lo_q;

  assign dec_tick = &dec_cnt;

  // strobe_q marks the cycle in which freshly decimated I/Q are visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt  <= '0;
      strobe_q <= 1'b0;
    end else begin
      dec_cnt  <= dec_cnt + DEC_LOG2'(1);
      strobe_q <= dec_tick;
    end
  end

  cic3_decim #(
    .CIC_W (CIC_W),
    .OUT_W (IQ_W)
  ) u_cic_i (
    .clk    (clk),
    .rst    (rst),
    .in_bit (i_bit),
    .tick   (dec_tick),
    .sample (i_sample)
  );

  cic3_decim #(
    .CIC_W (CIC_W),
    .OUT_W (IQ_W)
  ) u_cic_q (
    .clk    (clk),
    .rst    (rst),
    .in_bit (q_bit),
    .tick   (dec_tick),
    .sample (q_sample)
  );

  // Alpha-max-plus-half-beta-min envelope, gain shift and saturation to 8 bits.
  always_comb begin
    // NOTE: every variable here is assigned on every path, so no latch is inferred.
    abs_i = mag_abs(i_sample);
    abs_q = mag_abs(q_sample);
    if (abs_i >= abs_q) begin
      env_max = abs_i;
      env_min = abs_q;
    end else begin
      env_max = abs_q;
      env_min = abs_i;
    end
    mag        = env_max + (env_min >> 1);
    scaled     = 24'(mag) << gain;
    shifted    = 15'(scaled >> AUDIO_SHIFT);
    audio_next = (shifted > 15'd255) ? 8'hFF : shifted[7:0];
  end

  // First-order sigma-delta: the carry out of the 8-bit accumulator is the audio bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      audio  <= '0;
      sd_acc <= '0;
    end else begin
      if (strobe_q) begin
        audio <= audio_next;
      end
      sd_acc <= {1'b0, sd_acc[AUDIO_W-1:0]} + {1'b0, audio};
    end
  end

  always_comb begin
    uo_out                      = '0;
    uo_out[UO_SD_BIT]           = sd_acc[AUDIO_W];
    uo_out[UO_LO_I_BIT]         = lo_i;
    uo_out[UO_STROBE_BIT]       = strobe_q;
    uo_out[UO_AUDIO_LSB +: 5]   = audio[7:3];
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tiniest_1bit_am_receiver.sv
// Directed self-checking bench for tiniest_1bit_am_receiver.
module tb_tiniest_1bit_am_receiver;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int   checks = 0;
  int   errors = 0;
  logic follow_lo = 1'b0;

  tiniest_1bit_am_receiver dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clock; outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk);
    if (follow_lo) ui_in[0] = uo_out[1];
  endtask

  task automatic write_tw(input logic [1:0] sel, input logic [7:0] data);
    ui_in[2:1] = sel;
    ui_in[3]   = 1'b1;
    uio_in     = data;
    step();
    ui_in[3]   = 1'b0;
  endtask

  task automatic wait_strobes(input string tag, input int count);
    int missed;
    int n;
    missed = 0;
    for (int s = 0; s < count; s++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!uo_out[2] && n < 300);
      if (!uo_out[2]) missed++;
    end
    check(tag, missed, 0);
  endtask

  task automatic sample_bits(input int idx, input int n, output int ones, output int toggles);
    logic prev;
    prev    = uo_out[idx];
    ones    = 0;
    toggles = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (uo_out[idx]) ones++;
      if (uo_out[idx] != prev) toggles++;
      prev = uo_out[idx];
    end
  endtask

  initial begin
    int n;
    int ones;
    int toggles;

    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    step();
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    step();
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);

    // DC input: rf=0, tw=0, gain=0.
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst    = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!uo_out[2] && n < 300);
    check("first_strobe_cycle", n, 256);
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) check("strobe_width", uo_out[2], 1'b0);
    end while (!uo_out[2] && n < 300);
    check("strobe_period", n, 256);

    wait_strobes("dc_strobes", 3);
    repeat (3) step();
    check("dc_audio_hi", uo_out[7:3], 5'b00110);
    check("dc_lo_i", uo_out[1], 1'b0);
    sample_bits(0, 256, ones, toggles);
    check("dc_sd_ones", ones, 48);

    // Saturation: gain=3 gives 24576*8/512 = 384 -> 255.
    ui_in[6:4] = 3'd3;
    wait_strobes("sat_strobes", 1);
    repeat (2) step();
    check("sat_audio_hi", uo_out[7:3], 5'b11111);
    sample_bits(0, 256, ones, toggles);
    check("sat_sd_ones", ones, 255);

    // Tuning: tw=0x400000 -> lo_i period 4; tw=0x040000 -> period 64.
    ui_in[6:4] = 3'd0;
    write_tw(2'd2, 8'h40);
    write_tw(2'd1, 8'h00);
    write_tw(2'd0, 8'h00);
    sample_bits(1, 64, ones, toggles);
    check("tw400000_ones", ones, 32);
    check("tw400000_toggles", toggles, 32);
    write_tw(2'd2, 8'h04);
    sample_bits(1, 256, ones, toggles);
    check("tw040000_ones", ones, 128);
    check("tw040000_toggles", toggles, 8);

    // Locked carrier: rf follows lo_i so the synchronized bit is always ~lo_i.
    write_tw(2'd2, 8'h40);
    follow_lo = 1'b1;
    wait_strobes("lock_strobes", 6);
    repeat (3) step();
    check("lock_audio_hi", uo_out[7:3], 5'b00100);
    sample_bits(0, 256, ones, toggles);
    check_range("lock_sd_ones", ones, 31, 33);

    // Reset mid-run discards tw as well.
    rst = 1'b1;
    step();
    check("midrst_uo_out", uo_out, 8'h00);
    check("midrst_uio_oe", uio_oe, 8'h00);
    rst = 1'b0;
    write_tw(2'd3, 8'h40);
    sample_bits(1, 64, ones, toggles);
    check("post_reset_lo_i_ones", ones, 0);

    // Write latency: tw written at edge W is first added at edge W+1.
    write_tw(2'd2, 8'h40);
    check("tw_lat_w", uo_out[1], 1'b0);
    step();
    check("tw_lat_w1", uo_out[1], 1'b0);
    step();
    check("tw_lat_w2", uo_out[1], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
